// File: rtl/sha256_avalon_master.sv
`default_nettype none
// ============================================================================
//  Module      : sha256_avalon_master
//  Description : Avalon-MM initiator that hashes one 512-bit block per
//                request on a SHA-256 register-mapped slave: writes the 16
//                message words, issues start/last_block, polls done and, for
//                a final block, reads back the 8 digest words.
//                Optional watchdog: define SHA256_MASTER_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module sha256_avalon_master #(
    parameter int POLL_GAP = 4,
    parameter int TIMEOUT  = 1024
) (
    input  logic         iClk,
    input  logic         iReset,
    input  logic         iStart,
    input  logic [511:0] iBlock,
    input  logic         iLastBlock,
    output logic         oBusy,
    output logic         oBlockDone,
    output logic         oDigestValid,
    output logic [255:0] oDigest,
    output logic         oError,
    output logic         oChipSelect_n,
    output logic         oWrite_n,
    output logic         oRead_n,
    output logic [7:0]   oAddress,
    output logic [31:0]  oData,
    input  logic [31:0]  iData
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_MSG  = 3'd1,
        S_WR_CTRL = 3'd2,
        S_GAP     = 3'd3,
        S_POLL    = 3'd4,
        S_RD_DIG  = 3'd5,
        S_FINISH  = 3'd6
    } state_t;

    localparam logic [7:0] c_addr_ctrl  = 8'h10;
    localparam logic [7:0] c_addr_dig   = 8'h80;
    localparam logic [7:0] c_gap_last   = 8'(POLL_GAP - 1);
    // With no idle gap the master polls back-to-back
    localparam state_t     c_after_ctrl = (POLL_GAP == 0) ? S_POLL : S_GAP;

    state_t             r_state, w_state;
    logic [15:0][31:0]  r_block, w_block;      // word 0 sits in element 15
    logic               r_last, w_last;
    logic               r_armed, w_armed;      // a done=0 has been observed
    logic [3:0]         r_k, w_k;
    logic [2:0]         r_j, w_j;
    logic [7:0]         r_g, w_g;
    logic [7:0][31:0]   r_shadow, w_shadow;    // word 0 sits in element 7
    logic [7:0][31:0]   r_digest, w_digest;
    logic               r_busy, w_busy;
    logic               r_block_done, w_block_done;
    logic               r_digest_valid, w_digest_valid;
    logic               r_cs_n, w_cs_n;
    logic               r_wr_n, w_wr_n;
    logic               r_rd_n, w_rd_n;
    logic [7:0]         r_addr, w_addr;
    logic [31:0]        r_data, w_data;

`ifdef SHA256_MASTER_TIMEOUT_EN
    localparam int c_to_w = $clog2(TIMEOUT + 1);
    localparam logic [c_to_w-1:0] c_to_last = c_to_w'(TIMEOUT - 1);
    logic [c_to_w-1:0]  r_to, w_to;
    logic               r_error, w_error;
`endif

    // State register
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state;
        end
    end

    // Next state, counters and the bus cycle to present in the next clock
    always_comb begin
        w_state        = r_state;
        w_block        = r_block;
        w_last         = r_last;
        w_armed        = r_armed;
        w_k            = r_k;
        w_j            = r_j;
        w_g            = r_g;
        w_shadow       = r_shadow;
        w_digest       = r_digest;
        w_block_done   = 1'b0;
        w_digest_valid = 1'b0;
`ifdef SHA256_MASTER_TIMEOUT_EN
        w_to           = r_to;
        w_error        = r_error;
`endif

        case (r_state)
            S_IDLE: begin
                if (iStart) begin
                    w_block = iBlock;
                    w_last  = iLastBlock;
                    w_armed = 1'b0;
                    w_k     = 4'd0;
                    w_state = S_WR_MSG;
`ifdef SHA256_MASTER_TIMEOUT_EN
                    w_error = 1'b0;
`endif
                end
            end
            S_WR_MSG: begin
                w_k = r_k + 4'd1;
                if (r_k == 4'd15) begin
                    w_state = S_WR_CTRL;
                end
            end
            S_WR_CTRL: begin
                w_g     = 8'd0;
                w_state = c_after_ctrl;
`ifdef SHA256_MASTER_TIMEOUT_EN
                w_to    = '0;
`endif
            end
            S_GAP: begin
                if (r_g == c_gap_last) begin
                    w_state = S_POLL;
                end else begin
                    w_g = r_g + 8'd1;
                end
            end
            S_POLL: begin
                w_g = 8'd0;
                if (!iData[0]) begin
                    w_armed = 1'b1;
                    w_state = c_after_ctrl;
                end else if (r_armed) begin
                    w_block_done = 1'b1;
                    w_j          = 3'd0;
                    w_state      = r_last ? S_RD_DIG : S_FINISH;
                end else begin
                    // done still set from a previous block: not ours yet
                    w_state = c_after_ctrl;
                end
            end
            S_RD_DIG: begin
                w_shadow[~r_j] = iData;
                w_j            = r_j + 3'd1;
                if (r_j == 3'd7) begin
                    // Publish the complete shadow so oDigest is updated in
                    // the FINISH cycle, never with partial words
                    w_digest       = w_shadow;
                    w_digest_valid = 1'b1;
                    w_state        = S_FINISH;
                end
            end
            S_FINISH: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

`ifdef SHA256_MASTER_TIMEOUT_EN
        // Watchdog over the wait-for-done phase; completion wins a tie
        if ((r_state == S_GAP || r_state == S_POLL) &&
            !(r_state == S_POLL && iData[0] && r_armed)) begin
            if (r_to == c_to_last) begin
                w_state = S_IDLE;
                w_error = 1'b1;
            end else begin
                w_to = r_to + 1'b1;
            end
        end
`endif

        w_cs_n = 1'b1;
        w_wr_n = 1'b1;
        w_rd_n = 1'b1;
        w_addr = 8'h00;
        w_data = 32'h0;
        case (w_state)
            S_WR_MSG: begin
                w_cs_n = 1'b0;
                w_wr_n = 1'b0;
                w_addr = {4'h0, w_k};
                w_data = w_block[~w_k];
            end
            S_WR_CTRL: begin
                w_cs_n = 1'b0;
                w_wr_n = 1'b0;
                w_addr = c_addr_ctrl;
                w_data = {30'h0, 1'b1, w_last};
            end
            S_POLL: begin
                w_cs_n = 1'b0;
                w_rd_n = 1'b0;
                w_addr = c_addr_ctrl;
            end
            S_RD_DIG: begin
                w_cs_n = 1'b0;
                w_rd_n = 1'b0;
                w_addr = c_addr_dig | {5'h0, w_j};
            end
            default: begin
            end
        endcase

        // A final block releases busy together with oDigestValid; a
        // non-final block keeps busy through its FINISH cycle
        w_busy = !((w_state == S_IDLE) || (w_state == S_FINISH && w_last));
    end

    // Datapath, counters and registered outputs
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            r_block        <= '0;
            r_last         <= 1'b0;
            r_armed        <= 1'b0;
            r_k            <= 4'd0;
            r_j            <= 3'd0;
            r_g            <= 8'd0;
            r_shadow       <= '0;
            r_digest       <= '0;
            r_busy         <= 1'b0;
            r_block_done   <= 1'b0;
            r_digest_valid <= 1'b0;
            r_cs_n         <= 1'b1;
            r_wr_n         <= 1'b1;
            r_rd_n         <= 1'b1;
            r_addr         <= 8'h00;
            r_data         <= 32'h0;
        end else begin
            r_block        <= w_block;
            r_last         <= w_last;
            r_armed        <= w_armed;
            r_k            <= w_k;
            r_j            <= w_j;
            r_g            <= w_g;
            r_shadow       <= w_shadow;
            r_digest       <= w_digest;
            r_busy         <= w_busy;
            r_block_done   <= w_block_done;
            r_digest_valid <= w_digest_valid;
            r_cs_n         <= w_cs_n;
            r_wr_n         <= w_wr_n;
            r_rd_n         <= w_rd_n;
            r_addr         <= w_addr;
            r_data         <= w_data;
        end
    end

`ifdef SHA256_MASTER_TIMEOUT_EN
    // Watchdog counter and sticky error flag
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            r_to    <= '0;
            r_error <= 1'b0;
        end else begin
            r_to    <= w_to;
            r_error <= w_error;
        end
    end

    assign oError = r_error;
`else
    assign oError = 1'b0;
`endif

    assign oBusy         = r_busy;
    assign oBlockDone    = r_block_done;
    assign oDigestValid  = r_digest_valid;
    assign oDigest       = r_digest;
    assign oChipSelect_n = r_cs_n;
    assign oWrite_n      = r_wr_n;
    assign oRead_n       = r_rd_n;
    assign oAddress      = r_addr;
    assign oData         = r_data;

endmodule
`default_nettype wire

// File: doc/sha256_avalon_master.md
# sha256_avalon_master

Avalon-MM initiator that drives the SHA-256 Avalon slave's register map to hash one 512-bit block per request. It writes the 16 message words, pulses start/last_block through the control register, and polls the done bit. For final blocks it also reads the 8 digest words back. It sits between a local producer (DMA or packet parser) and the SHA-256 slave, replacing CPU-driven register access.

## Interface
Parameters:
- POLL_GAP, 4: idle bus cycles between consecutive control-register polls (0..255).
- TIMEOUT, 1024: maximum poll-state cycles before abort (used only with SHA256_MASTER_TIMEOUT_EN).

Ports:
- iClk  in  1  clock; all logic on rising edge.
- iReset  in  1  asynchronous, active-high reset.
- iStart  in  1  request; accepted only when oBusy=0.
- iBlock  in  512  message block; bits [511:480] are word 0.
- iLastBlock  in  1  request is the final block of the message.
- oBusy  out  1  request in progress.
- oBlockDone  out  1  one-cycle pulse when the core reports done for the current block.
- oDigestValid  out  1  one-cycle pulse when oDigest has been updated.
- oDigest  out  256  final digest; word k occupies [255-32k -: 32].
- oError  out  1  sticky timeout flag; cleared when the next request is accepted.
- oChipSelect_n, oWrite_n, oRead_n  out  1 each  Avalon strobes, active-low.
- oAddress  out  8  word address.
- oData  out  32  write data.
- iData  in  32  read data; combinational from the slave and valid in the same cycle as the read strobe.

## Operation
Slave map:
- 0x00–0x0F: message word k written at address k.
- 0x10: control. Write bit1 = start, bit0 = last_block. Read bit0 = done, bit1 = start, bit2 = last_block, bit3 = digest_update.
- 0x80–0x87: digest word k read at 0x80+k.

The slave has no waitrequest, so every access completes in one cycle.

FSM states: IDLE, WR_MSG, WR_CTRL, GAP, POLL, RD_DIG, FINISH.
- IDLE: if iStart is high, latch iBlock and iLastBlock, clear oError and the armed flag, and go to WR_MSG.
- WR_MSG: a 4-bit counter k runs 0..15. Write address k with the latched word k. After k=15, go to WR_CTRL.
- WR_CTRL: write address 0x10 with data {30'b0, 1'b1, last}, then go to GAP.
- GAP: the bus is idle for POLL_GAP cycles, then go to POLL. If POLL_GAP=0, go straight to POLL.
- POLL: read 0x10 for one cycle.
  - iData[0]=0: set armed and return to GAP.
  - iData[0]=1 and armed: pulse oBlockDone. Go to RD_DIG if last, else FINISH.
  - iData[0]=1 and not armed: this is a stale done; return to GAP.
- RD_DIG: a 3-bit counter j runs 0..7. Read 0x80+j and capture iData into a shadow register, word j. After j=7, go to FINISH.
- FINISH: if last, copy the shadow into oDigest and pulse oDigestValid. Go to IDLE.

Other rules:
- oDigest changes only in FINISH of a last block. Partial reads never appear on oDigest.
- iStart is ignored while oBusy=1. Changes to iBlock after acceptance have no effect.
- Idle bus: all strobes high, oAddress=0, oData=0.

## Timing
- All outputs are registered.
- Reset values: oBusy=0, oBlockDone=0, oDigestValid=0, oDigest=0, oError=0, strobes=1, oAddress=0, oData=0, FSM=IDLE, counters=0.
- Reset mid-operation: the bus returns to idle asynchronously and the request is dropped with no pulses.
- Acceptance at edge T (iStart sampled high):
  - oBusy=1 from T.
  - Message writes on cycles T..T+15.
  - Control write on T+16.
  - First poll on T+17+POLL_GAP.
- If a poll at cycle P completes the block:
  - oBlockDone is high in cycle P+1.
  - Digest reads occupy P+1..P+8.
  - oDigestValid is high and oBusy drops in P+9.
- Non-last block: FINISH is cycle P+1 and oBusy drops in P+2.
- iStart may be accepted in the cycle after oBusy falls.

## Configuration
- SHA256_MASTER_TIMEOUT_EN defined:
  - A cycle counter runs from WR_CTRL exit.
  - When it reaches TIMEOUT before completion, set oError, force the bus idle, and go to IDLE.
  - No oBlockDone or oDigestValid pulse is issued.
- Undefined: no counter; POLL repeats indefinitely and oError is tied to 0.

## Test plan
- "abc" single block: iBlock=0x61626380 followed by 0s with final word 0x00000018, iLastBlock=1. Required: oDigest=ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, exactly one oDigestValid pulse.
- Bus trace: 16 writes at addresses 0x00..0x0F with the block words in order, then a write of 0x10←0x3, then a read of 0x10 after exactly 4 idle cycles.
- Two-block message (non-last, then last): the first block gives oBlockDone only, with no oDigestValid and oDigest still 0. The second block yields the correct 448-bit-message digest.
- Stale done: a slave model holding done=1 for 10 cycles after start. The master must not complete until after it has observed done=0.
- iStart held high during a busy request: ignored, with exactly 16 writes per accepted request. Reset asserted mid-WR_MSG: strobes go high immediately and no pulses follow.
- With SHA256_MASTER_TIMEOUT_EN and TIMEOUT=64, a slave that never asserts done: oError=1 and oBusy=0 within 64 cycles. The next iStart clears oError.
